// File: rtl/mfcc_pkg.sv
// Shared MFCC-core types, Q1.15 constants and the sample saturation helper.
package mfcc_pkg;

  localparam int          DEFAULT_SAMPLE_WIDTH = 16;
  localparam int          Q15_FRAC_BITS        = 15;
  localparam logic [15:0] ALPHA_DEFAULT        = 16'd31785;

  typedef logic signed [DEFAULT_SAMPLE_WIDTH-1:0] sample_t;

  // Clamp a two-bit-headroom sum into the sample range.
  function automatic sample_t sat_to_sample(input logic signed [DEFAULT_SAMPLE_WIDTH+1:0] s);
    logic signed [DEFAULT_SAMPLE_WIDTH+1:0] smax;
    logic signed [DEFAULT_SAMPLE_WIDTH+1:0] smin;
    smax = {3'b000, {(DEFAULT_SAMPLE_WIDTH-1){1'b1}}};
    smin = {3'b111, {(DEFAULT_SAMPLE_WIDTH-1){1'b0}}};
    if (s > smax)      sat_to_sample = smax[DEFAULT_SAMPLE_WIDTH-1:0];
    else if (s < smin) sat_to_sample = smin[DEFAULT_SAMPLE_WIDTH-1:0];
    else               sat_to_sample = s[DEFAULT_SAMPLE_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/q15_mac_sat.sv
// Combinational Q1.15 multiply-accumulate: addend + round(acc * coef), saturated to W bits.
module q15_mac_sat
  import mfcc_pkg::*;
#(
  parameter int W  = 16,
  parameter int CW = 16
) (
  input  logic signed [W-1:0]  acc_i,
  input  logic        [CW-1:0] coef_i,
  input  logic signed [W-1:0]  addend_i,
  output logic signed [W-1:0]  sum_o,
  output logic                 clip_o
);

  localparam logic signed [W+CW:0] HALF = (W+CW+1)'(1) <<< (Q15_FRAC_BITS - 1);
  localparam logic signed [W+1:0]  SMAX = {3'b000, {(W-1){1'b1}}};
  localparam logic signed [W+1:0]  SMIN = {3'b111, {(W-1){1'b0}}};

  logic signed [CW:0]   coef_s;
  logic signed [W+CW:0] prod;
  logic signed [W+1:0]  fb;
  logic signed [W+1:0]  sum;

  assign coef_s = $signed({1'b0, coef_i});
  assign prod   = acc_i * coef_s;
  // Coefficient < 1.0, so the rounded feedback always fits in W+2 bits.
  assign fb     = (W+2)'((prod + HALF) >>> Q15_FRAC_BITS);
  assign sum    = $signed({{2{addend_i[W-1]}}, addend_i}) + fb;

  always_comb begin
    clip_o = 1'b0;
    sum_o  = sum[W-1:0];
    if (sum > SMAX) begin
      clip_o = 1'b1;
      sum_o  = SMAX[W-1:0];
    end else if (sum < SMIN) begin
      clip_o = 1'b1;
      sum_o  = SMIN[W-1:0];
    end
  end

endmodule

// File: rtl/de_emphasis.sv
// First-order IIR de-emphasis y[n] = x[n] + ALPHA*y[n-1] with valid/ready streaming.
// Optional saturating clip counter enabled by `define DE_EMPHASIS_CLIP_CNT_EN.
module de_emphasis
  import mfcc_pkg::*;
#(
  parameter int          SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
  parameter logic [15:0] ALPHA        = ALPHA_DEFAULT  // Q1.15, must stay below 16'd32768
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [SAMPLE_WIDTH-1:0] x_in,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [SAMPLE_WIDTH-1:0] y_out,
  output logic                           out_last,
  output logic                           clip,
  output logic [15:0]                    clip_count
);

  logic signed [SAMPLE_WIDTH-1:0] y_prev_q, y_prev_d;
  logic signed [SAMPLE_WIDTH-1:0] y_q, y_d;
  logic                           valid_q, valid_d;
  logic                           last_q, last_d;
  logic                           clip_q, clip_d;
  logic signed [SAMPLE_WIDTH-1:0] mac_y;
  logic                           mac_clip;
  logic                           accept;

  q15_mac_sat #(
    .W  (SAMPLE_WIDTH),
    .CW (16)
  ) u_mac (
    .acc_i    (y_prev_q),
    .coef_i   (ALPHA),
    .addend_i (x_in),
    .sum_o    (mac_y),
    .clip_o   (mac_clip)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    y_prev_d = y_prev_q;
    y_d      = y_q;
    valid_d  = valid_q;
    last_d   = last_q;
    clip_d   = clip_q;
    if (accept) begin
      y_d      = mac_y;
      valid_d  = 1'b1;
      last_d   = in_last;
      clip_d   = mac_clip;
      // Frame end zeroes the history; this beat still used the old y_prev.
      y_prev_d = in_last ? '0 : mac_y;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_prev_q <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      clip_q   <= 1'b0;
    end else begin
      y_prev_q <= y_prev_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      clip_q   <= clip_d;
    end
  end

  assign out_valid = valid_q;
  assign y_out     = y_q;
  assign out_last  = last_q;
  assign clip      = clip_q;

`ifdef DE_EMPHASIS_CLIP_CNT_EN
  logic [15:0] clip_cnt_q, clip_cnt_d;

  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (valid_q && out_ready && clip_q && (clip_cnt_q != 16'hFFFF))
      clip_cnt_d = clip_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clip_cnt_q <= '0;
    else        clip_cnt_q <= clip_cnt_d;
  end

  assign clip_count = clip_cnt_q;
`else
  assign clip_count = 16'd0;
`endif

endmodule

// File: doc/de_emphasis.md
Name: de_emphasis

Overview:
- First-order IIR de-emphasis filter: y[n] = x[n] + ALPHA·y[n-1], Q1.15 coefficient.
- Exact inverse of the pre-emphasis stage. Sits on the resynthesis/loopback path of the MFCC core, so verification can undo pre-emphasis and compare the result against the raw audio.
- Streams samples with valid/ready handshake on both sides.
- Supports per-frame state reset and saturating output.

Parameters:
- SAMPLE_WIDTH, 16, width of signed two's-complement input/output samples
- ALPHA, 16'd31785, feedback coefficient, unsigned Q1.15 (0.97); must be < 32768

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  x_in/in_last valid
- in_ready  output  1  block can accept a sample this cycle
- x_in  input  SAMPLE_WIDTH  signed input sample x[n]
- in_last  input  1  last sample of frame; clears filter state after it
- out_valid  output  1  y_out valid
- out_ready  input  1  downstream accepts y_out
- y_out  output  SAMPLE_WIDTH  signed de-emphasised sample y[n]
- out_last  output  1  in_last delayed alongside y_out
- clip  output  1  y_out for this beat was saturated
- clip_count  output  16  saturating count of clipped samples (feature-dependent)

Behaviour:
- Reset values: out_valid=0, y_out=0, out_last=0, clip=0, y_prev=0, clip_count=0. in_ready=1 after reset.
- Output stage is a single register slot: in_ready = !out_valid || out_ready (combinational).
- Accept occurs when in_valid && in_ready. Latency is 1 cycle: result is registered and out_valid=1 on the next edge. Full throughput is 1 sample/cycle when out_ready is held high.
- Output pop without a new accept: out_valid → 0.
- Backpressure (out_valid=1, out_ready=0): y_out, out_last, clip and y_prev are held stable. in_ready=0.
- Arithmetic, evaluated per accepted sample:
  - prod = signed(y_prev) · signed({1'b0,ALPHA}), 2·SAMPLE_WIDTH+1 bits.
  - fb = (prod + 2^14) >>> 15, arithmetic shift, round-half-up.
  - sum = sext(x_in) + fb, SAMPLE_WIDTH+2 bits.
  - y = sum saturated to [-2^(W-1), 2^(W-1)-1]; clip=1 if saturation occurred, else 0.
- State update on accept:
  - y_prev ← y (the saturated value, never the unsaturated sum).
  - If in_last=1, y_prev ← 0 instead, so the next frame starts from zero state. The current output still uses the old y_prev.
- No accept: y_prev unchanged.
- Simultaneous pop and accept in one cycle: new result replaces the old one; no bubble.
- Asynchronous reset mid-stream: all state drops to reset values immediately. An in-flight output is discarded; no partial beat is emitted.
- out_last mirrors in_last of the accepted sample. Frame-boundary timing is not otherwise altered.

Optional Feature:
- Macro DE_EMPHASIS_CLIP_CNT_EN.
- Defined:
  - clip_count increments on each output handshake (out_valid && out_ready) whose clip=1.
  - It saturates at 16'hFFFF.
  - It resets only via rst_n.
- Undefined: clip_count is tied to 16'd0 and no counter logic is generated. The port list is identical in both builds.

Decomposition:
- Shared package mfcc_pkg holds:
  - sample_t typedef (logic signed [SAMPLE_WIDTH-1:0])
  - Q15_FRAC_BITS=15 constant
  - ALPHA_DEFAULT=16'd31785 constant
  - sat_to_sample function, shared with pre_emphasis users
- One natural combinational sub-module: q15_mac_sat. It takes acc, coefficient and addend and returns the saturated sum plus the clip flag, so it can be reused by other Q1.15 stages.
- Handshake, state and counter logic stay in de_emphasis.

Test Plan:
- Impulse: after reset, out_ready=1, x=1000 then x=0,0 → y=1000, 970, 941. clip=0 throughout.
- Positive saturation: drive x=32767 continuously. Once y_prev=32767, the next x=32767 gives sum 64551 → y=32767, clip=1. With DE_EMPHASIS_CLIP_CNT_EN, clip_count increments by 1 per such beat.
- Negative saturation: with y_prev=-32768, x=-32768 → y=-32768, clip=1. Then x=0 → y=-31785.
- Frame reset: x=1000 with in_last=1 → y=1000, out_last=1. Next x=0 → y=0, not 970.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream → out_valid stays 1, y_out is stable, in_ready=0. On release, the sequence continues identically to the no-stall golden run. Also check simultaneous pop+accept produces no bubble.
- Async reset: assert rst_n=0 mid-cycle while out_valid=1 → out_valid=0, y_out=0 immediately. After release, x=1000 → y=1000, confirming y_prev was cleared.
